md_hazard_ctrl: RTL and testbench

- Pipeline hazard and multiply/divide scheduling controller for the 5-stage MIPS CPU.
- Takes the Tuse/Tnew classification from the decoder of the D-stage instruction, plus the destination register and Tnew of the E and M stages.
- Produces the stall and bubble controls for PC, F/D and D/E.
- Owns the MDU busy sequencer: shares the single HI/LO mult/div unit and holds any D-stage HI/LO instruction until the running operation completes.

---
 rtl/cpu_defs.sv | 28 ++
 rtl/md_busy_seq.sv | 68 ++++++
 rtl/md_hazard_ctrl.sv | 77 +++++++
 tb/tb_md_hazard_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the MIPS pipeline control slice: Tuse/Tnew encodings,
// multiply/divide latency defaults and the MDU sequencer state encoding.
package cpu_defs;

    typedef logic [1:0] tuse_t;
    typedef logic [1:0] tnew_t;

    // A Tuse of 3 means the operand is not read, so no Tnew can exceed it.
    localparam tuse_t TUSE_0    = 2'd0;
    localparam tuse_t TUSE_1    = 2'd1;
    localparam tuse_t TUSE_2    = 2'd2;
    localparam tuse_t TUSE_NONE = 2'd3;

    localparam tnew_t TNEW_0    = 2'd0;
    localparam tnew_t TNEW_1    = 2'd1;
    localparam tnew_t TNEW_2    = 2'd2;
    localparam tnew_t TNEW_NONE = 2'd3;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;
    localparam int unsigned CNT_W_DEF       = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_busy_seq.sv
// Busy sequencer for the shared HI/LO multiply/divide unit: counts down the
// operation latency after an E-stage start and pulses md_done on completion.
module md_busy_seq
    import cpu_defs::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic E_start,
    input  logic E_is_div,
    output logic md_busy,
    output logic md_done
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] load;

    assign load = E_is_div ? DIV_LOAD : MULT_LOAD;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (E_start) begin
                        state_q <= BUSY;
                        cnt_q   <= load;
                        busy_q  <= 1'b1;
                    end
                end
                BUSY: begin
                    // Completion still reports even if a new start lands on the last cycle.
                    if (cnt_q == CNT_LAST) begin
                        done_q <= 1'b1;
                    end
                    if (E_start) begin
                        cnt_q <= load;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_LAST;
                    end
                end
            endcase
        end
    end

    assign md_busy = busy_q;
    assign md_done = done_q;

endmodule

// File: rtl/md_hazard_ctrl.sv
// Hazard and multiply/divide scheduling control for the 5-stage MIPS pipeline:
// register Tuse/Tnew stalls, HI/LO structural stalls and a stall-cycle counter.
module md_hazard_ctrl
    import cpu_defs::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_tuse_rs,
    input  logic [1:0]  D_tuse_rt,
    input  logic        D_md,
    input  logic [4:0]  E_waddr,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  M_waddr,
    input  logic [1:0]  M_tnew,
    input  logic        E_start,
    input  logic        E_is_div,
    output logic        stall,
    output logic        pc_en,
    output logic        fd_en,
    output logic        de_clr,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cycles
);

    logic        hz_rs;
    logic        hz_rt;
    logic        hz_md;
    logic [31:0] stall_cycles_q;

    // Equal Tnew/Tuse is resolved by forwarding, so only a strictly later result stalls.
    assign hz_rs = (D_rs != 5'd0) &&
                   (((E_waddr == D_rs) && (E_tnew > D_tuse_rs)) ||
                    ((M_waddr == D_rs) && (M_tnew > D_tuse_rs)));

    assign hz_rt = (D_rt != 5'd0) &&
                   (((E_waddr == D_rt) && (E_tnew > D_tuse_rt)) ||
                    ((M_waddr == D_rt) && (M_tnew > D_tuse_rt)));

    // E_start covers the cycle before md_busy rises.
    assign hz_md = D_md && (md_busy || E_start);

    assign stall  = hz_rs | hz_rt | hz_md;
    assign pc_en  = ~stall;
    assign fd_en  = ~stall;
    assign de_clr = stall;

    md_busy_seq #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_seq (
        .clk      (clk),
        .reset    (reset),
        .E_start  (E_start),
        .E_is_div (E_is_div),
        .md_busy  (md_busy),
        .md_done  (md_done)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles_q <= 32'd0;
        end else if (stall) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_md_hazard_ctrl.sv
// Scoreboard bench for md_hazard_ctrl: expected outputs are queued per cycle and
// compared against the DUT away from the rising edge.
module tb_md_hazard_ctrl;
    import cpu_defs::*;

    logic        clk;
    logic        reset;
    logic [4:0]  D_rs;
    logic [4:0]  D_rt;
    logic [1:0]  D_tuse_rs;
    logic [1:0]  D_tuse_rt;
    logic        D_md;
    logic [4:0]  E_waddr;
    logic [1:0]  E_tnew;
    logic [4:0]  M_waddr;
    logic [1:0]  M_tnew;
    logic        E_start;
    logic        E_is_div;
    logic        stall;
    logic        pc_en;
    logic        fd_en;
    logic        de_clr;
    logic        md_busy;
    logic        md_done;
    logic [31:0] stall_cycles;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t   sb[$];
    int          checks;
    int          errors;
    logic [31:0] exp_sc;

    md_hazard_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .D_rs         (D_rs),
        .D_rt         (D_rt),
        .D_tuse_rs    (D_tuse_rs),
        .D_tuse_rt    (D_tuse_rt),
        .D_md         (D_md),
        .E_waddr      (E_waddr),
        .E_tnew       (E_tnew),
        .M_waddr      (M_waddr),
        .M_tnew       (M_tnew),
        .E_start      (E_start),
        .E_is_div     (E_is_div),
        .stall        (stall),
        .pc_en        (pc_en),
        .fd_en        (fd_en),
        .de_clr       (de_clr),
        .md_busy      (md_busy),
        .md_done      (md_done),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            0:       return {31'd0, stall};
            1:       return {31'd0, pc_en};
            2:       return {31'd0, fd_en};
            3:       return {31'd0, de_clr};
            4:       return {31'd0, md_busy};
            5:       return {31'd0, md_done};
            default: return stall_cycles;
        endcase
    endfunction

    task automatic idle_inputs();
        D_rs      = 5'd0;
        D_rt      = 5'd0;
        D_tuse_rs = TUSE_NONE;
        D_tuse_rt = TUSE_NONE;
        D_md      = 1'b0;
        E_waddr   = 5'd0;
        E_tnew    = TNEW_0;
        M_waddr   = 5'd0;
        M_tnew    = TNEW_0;
        E_start   = 1'b0;
        E_is_div  = 1'b0;
    endtask

    // Inputs are already applied at the falling edge; check, then advance one cycle.
    task automatic cyc(input string tag, input logic es, input logic eb, input logic ed);
        sb_entry_t e;
        #1;
        sb.push_back('{{tag, ".stall"}, 0, {31'd0, es}});
        sb.push_back('{{tag, ".pc_en"}, 1, {31'd0, ~es}});
        sb.push_back('{{tag, ".fd_en"}, 2, {31'd0, ~es}});
        sb.push_back('{{tag, ".de_clr"}, 3, {31'd0, es}});
        sb.push_back('{{tag, ".md_busy"}, 4, {31'd0, eb}});
        sb.push_back('{{tag, ".md_done"}, 5, {31'd0, ed}});
        sb.push_back('{{tag, ".stall_cycles"}, 6, exp_sc});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, observe(e.sig), e.exp);
        end
        @(posedge clk);
        if (!reset) exp_sc = 32'd0;
        else if (es) exp_sc = exp_sc + 32'd1;
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_sc = 32'd0;
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc("reset", 1'b0, 1'b0, 1'b0);

        // Register hazards.
        E_waddr = 5'd8; E_tnew = TNEW_2; D_rs = 5'd8; D_tuse_rs = TUSE_1;
        cyc("hz_e_rs", 1'b1, 1'b0, 1'b0);
        E_tnew = TNEW_1;
        cyc("eq_tnew", 1'b0, 1'b0, 1'b0);
        E_tnew = TNEW_2; D_rs = 5'd0;
        cyc("reg0", 1'b0, 1'b0, 1'b0);
        idle_inputs();
        M_waddr = 5'd9; M_tnew = TNEW_1; D_rt = 5'd9; D_tuse_rt = TUSE_0;
        cyc("hz_m_rt", 1'b1, 1'b0, 1'b0);
        idle_inputs();
        E_waddr = 5'd0; D_rs = 5'd0; D_rt = 5'd3; D_tuse_rt = TUSE_NONE;
        M_waddr = 5'd3; M_tnew = TNEW_2;
        cyc("tuse_none", 1'b0, 1'b0, 1'b0);

        // Multiply: start at t, busy t+1..t+5, done at t+6.
        idle_inputs();
        D_md = 1'b1; E_start = 1'b1; E_is_div = 1'b0;
        cyc("mult_t0", 1'b1, 1'b0, 1'b0);
        E_start = 1'b0;
        for (int i = 1; i <= 5; i++) cyc($sformatf("mult_t%0d", i), 1'b1, 1'b1, 1'b0);
        cyc("mult_done", 1'b0, 1'b0, 1'b1);
        cyc("mult_after", 1'b0, 1'b0, 1'b0);

        // Divide with a register hazard overlapping: still a single stall.
        E_start = 1'b1; E_is_div = 1'b1;
        cyc("div_t0", 1'b1, 1'b0, 1'b0);
        E_start = 1'b0;
        E_waddr = 5'd4; E_tnew = TNEW_2; D_rs = 5'd4; D_tuse_rs = TUSE_0;
        cyc("div_t1_both", 1'b1, 1'b1, 1'b0);
        idle_inputs();
        D_md = 1'b1;
        for (int i = 2; i <= 10; i++) cyc($sformatf("div_t%0d", i), 1'b1, 1'b1, 1'b0);
        cyc("div_done", 1'b0, 1'b0, 1'b1);

        // Second divide, reset at its fourth busy cycle.
        E_start = 1'b1; E_is_div = 1'b1;
        cyc("div2_t0", 1'b1, 1'b0, 1'b0);
        E_start = 1'b0;
        for (int i = 1; i <= 3; i++) cyc($sformatf("div2_t%0d", i), 1'b1, 1'b1, 1'b0);
        reset = 1'b0;
        cyc("div2_rst", 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        cyc("after_rst", 1'b0, 1'b0, 1'b0);

        // Divide, then a multiply started on its last busy cycle: no idle gap.
        E_start = 1'b1; E_is_div = 1'b1;
        cyc("div3_t0", 1'b1, 1'b0, 1'b0);
        E_start = 1'b0;
        for (int i = 1; i <= 9; i++) cyc($sformatf("div3_t%0d", i), 1'b1, 1'b1, 1'b0);
        E_start = 1'b1; E_is_div = 1'b0;
        cyc("div3_t10_start", 1'b1, 1'b1, 1'b0);
        E_start = 1'b0;
        cyc("b2b_t1_done", 1'b1, 1'b1, 1'b1);
        for (int i = 2; i <= 5; i++) cyc($sformatf("b2b_t%0d", i), 1'b1, 1'b1, 1'b0);
        cyc("b2b_done", 1'b0, 1'b0, 1'b1);

        // Start mid-busy reloads the counter and suppresses the overwritten done.
        E_start = 1'b1; E_is_div = 1'b0;
        cyc("rl_t0", 1'b1, 1'b0, 1'b0);
        E_start = 1'b0;
        cyc("rl_t1", 1'b1, 1'b1, 1'b0);
        E_start = 1'b1; E_is_div = 1'b0;
        cyc("rl_t2_reload", 1'b1, 1'b1, 1'b0);
        E_start = 1'b0;
        for (int i = 1; i <= 5; i++) cyc($sformatf("rl_r%0d", i), 1'b1, 1'b1, 1'b0);
        cyc("rl_done", 1'b0, 1'b0, 1'b1);
        D_md = 1'b0;
        cyc("final", 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
